// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - GPR/HI/LO register file with forwarding network, scoreboard and stall.
// Reads resolve combinationally from forwarding sources, the writeback port, then storage.
module regfile_bypass #(
    parameter int DW   = 32,
    parameter int NREG = 32,
    parameter int NFWD = 3,
    parameter int AW   = $clog2(NREG)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [AW-1:0]        raddr1,
    input  logic [AW-1:0]        raddr2,
    output logic [DW-1:0]        rdata1,
    output logic [DW-1:0]        rdata2,
    input  logic                 we,
    input  logic [AW-1:0]        waddr,
    input  logic [DW-1:0]        wdata,
    input  logic [NFWD-1:0]      fwd_we,
    input  logic [NFWD-1:0]      fwd_rdy,
    input  logic [NFWD*AW-1:0]   fwd_waddr,
    input  logic [NFWD*DW-1:0]   fwd_wdata,
    input  logic                 hi_we,
    input  logic                 lo_we,
    input  logic [DW-1:0]        hi_wdata,
    input  logic [DW-1:0]        lo_wdata,
    input  logic [NFWD-1:0]      fwd_hi_we,
    input  logic [NFWD-1:0]      fwd_lo_we,
    input  logic [NFWD*DW-1:0]   fwd_hi_wdata,
    input  logic [NFWD*DW-1:0]   fwd_lo_wdata,
    input  logic                 iss_long,
    input  logic [AW-1:0]        iss_waddr,
    input  logic                 iss_hilo,
    output logic [DW-1:0]        hi_rdata,
    output logic [DW-1:0]        lo_rdata,
    output logic                 stall
);

    logic [DW-1:0]   gpr [NREG];
    logic [NREG-1:0] busy;
    logic [DW-1:0]   hi_q;
    logic [DW-1:0]   lo_q;
    logic            hilo_busy;
    logic            rd_stall1;
    logic            rd_stall2;
    logic            hi_act;
    logic            lo_act;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) gpr[r] <= '0;
            busy      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hilo_busy <= 1'b0;
        end else begin
            if (we && waddr != '0) gpr[waddr] <= wdata;
            if (hi_we) hi_q <= hi_wdata;
            if (lo_we) lo_q <= lo_wdata;
            // Entry 0 is never marked busy; an issue to the same register overrides its writeback clear.
            for (int r = 1; r < NREG; r++) begin
                if (iss_long && iss_waddr == r[AW-1:0])
                    busy[r] <= 1'b1;
                else if (we && waddr == r[AW-1:0])
                    busy[r] <= 1'b0;
            end
            if (iss_hilo)
                hilo_busy <= 1'b1;
            else if (hi_we || lo_we)
                hilo_busy <= 1'b0;
        end
    end

    // Returns {stall, data}; the loop runs oldest to youngest so the lowest index wins.
    function automatic logic [DW:0] resolve_gpr(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        logic          hit;
        logic          rdy;
        d   = gpr[a];
        hit = 1'b0;
        rdy = 1'b1;
        if (we && waddr == a) begin
            d   = wdata;
            hit = 1'b1;
        end
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_we[i] && fwd_waddr[i*AW +: AW] == a) begin
                d   = fwd_wdata[i*DW +: DW];
                hit = 1'b1;
                rdy = fwd_rdy[i];
            end
        end
        if (a == '0) return '0;
        return {(hit && !rdy) || (busy[a] && !hit), d};
    endfunction

    // Returns {source_active, data} for HI or LO.
    function automatic logic [DW:0] resolve_hl(input logic [NFWD-1:0]    fwe,
                                               input logic [NFWD*DW-1:0] fd,
                                               input logic               wen,
                                               input logic [DW-1:0]      wd,
                                               input logic [DW-1:0]      q);
        logic [DW-1:0] d;
        d = wen ? wd : q;
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwe[i]) d = fd[i*DW +: DW];
        end
        return {wen || (|fwe), d};
    endfunction

    always_comb begin
        {rd_stall1, rdata1} = resolve_gpr(raddr1);
        {rd_stall2, rdata2} = resolve_gpr(raddr2);
        {hi_act, hi_rdata}  = resolve_hl(fwd_hi_we, fwd_hi_wdata, hi_we, hi_wdata, hi_q);
        {lo_act, lo_rdata}  = resolve_hl(fwd_lo_we, fwd_lo_wdata, lo_we, lo_wdata, lo_q);
        stall = resetn && (rd_stall1 || rd_stall2 || (hilo_busy && !(hi_act || lo_act)));
    end

endmodule
